// File: rtl/ram_io_responder_if.sv
// Byte-wide CPU memory bus between the memory controller (master) and the
// RAM/IO responder (slave).
//
// Handshake: the controller presents one access per cycle (mem_a, mem_wr,
// mem_dout) and it is consumed at the next rising edge. A read presented in
// cycle N returns mem_din in cycle N+1. cpu_rdy is the responder's registered
// backpressure: the controller may issue an IO write only while cpu_rdy=1,
// and such a write is always accepted.
interface ram_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        cpu_rdy;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        input  mem_din,
        input  cpu_rdy
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        output mem_din,
        output cpu_rdy
    );
endinterface

// File: rtl/ram_io_responder.sv
// RAM/IO responder: byte RAM with 1-cycle read latency, plus an IO window
// holding a TX queue (written at IO_BASE), an RX queue (read at IO_BASE) and
// a status byte (read at IO_BASE+4).
// The io_rx_* and io_tx_* ports are valid/ready streams: a byte moves at a
// rising edge where valid and ready are both 1.
module ram_io_responder #(
    parameter int          ADDR_WIDTH = 17,
    parameter logic [31:0] IO_BASE    = 32'h30000,
    parameter int          TXQ_DEPTH  = 8,
    parameter int          RXQ_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    ram_io_responder_if.slave   bus,
    input  logic                io_rx_valid,
    input  logic [7:0]          io_rx_data,
    output logic                io_rx_ready,
    output logic                io_tx_valid,
    output logic [7:0]          io_tx_data,
    input  logic                io_tx_ready,
    output logic                tx_overflow
);
    localparam int TXP = $clog2(TXQ_DEPTH);
    localparam int RXP = $clog2(RXQ_DEPTH);
    localparam logic [TXP:0] TX_FULL = TXQ_DEPTH[TXP:0];
    localparam logic [TXP:0] TX_LAST = TX_FULL - 1'b1;
    localparam logic [RXP:0] RX_FULL = RXQ_DEPTH[RXP:0];

    logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] tx_mem [0:TXQ_DEPTH-1];
    logic [7:0] rx_mem [0:RXQ_DEPTH-1];

    logic [TXP-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TXP:0]   tx_count_q, tx_count_d;
    logic [RXP-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RXP:0]   rx_count_q, rx_count_d;
    logic [7:0]     mem_din_q;
    logic           cpu_rdy_q, run_q, tx_overflow_q, io_rx_ready_q;

    logic [ADDR_WIDTH-1:0] idx;
    logic is_io, rd_base, rd_stat, wr_base;
    logic tx_full, rx_nonempty;
    logic tx_push, tx_pop, tx_drop, rx_push, rx_pop;

    // Address decode and queue handshakes for the current cycle.
    always_comb begin
        idx         = bus.mem_a[ADDR_WIDTH-1:0];
        is_io       = (bus.mem_a >= IO_BASE);
        rd_base     = !bus.mem_wr && (bus.mem_a == IO_BASE);
        rd_stat     = !bus.mem_wr && (bus.mem_a == IO_BASE + 32'd4);
        wr_base     = bus.mem_wr && (bus.mem_a == IO_BASE);
        tx_full     = (tx_count_q == TX_FULL);
        rx_nonempty = (rx_count_q != '0);
        tx_pop      = (tx_count_q != '0) && io_tx_ready;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        tx_push     = wr_base && (!tx_full || tx_pop);
        tx_drop     = wr_base && tx_full && !tx_pop;
        rx_push     = io_rx_valid && io_rx_ready_q;
        // Only the first cycle of a run of IO_BASE reads consumes an RX byte.
        rx_pop      = rd_base && !run_q && rx_nonempty;
    end

    // Next-state queue occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count_q + 1'b1;
        end else if (!tx_push && tx_pop) begin
            tx_count_d = tx_count_q - 1'b1;
        end
        if (rx_push && !rx_pop) begin
            rx_count_d = rx_count_q + 1'b1;
        end else if (!rx_push && rx_pop) begin
            rx_count_d = rx_count_q - 1'b1;
        end
    end

    // RAM and queue storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.mem_wr && !is_io) begin
            ram[idx] <= bus.mem_dout;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= bus.mem_dout;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= io_rx_data;
        end
    end

    // Control registers: pointers, counts, run flag, flags and read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            mem_din_q     <= 8'h00;
            cpu_rdy_q     <= 1'b1;
            run_q         <= 1'b0;
            tx_overflow_q <= 1'b0;
            io_rx_ready_q <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
            tx_count_q    <= tx_count_d;
            rx_count_q    <= rx_count_d;
            // Falls one cycle late, so one TX slot is kept for the write in flight.
            cpu_rdy_q     <= (tx_count_q < TX_LAST);
            run_q         <= rd_base;
            tx_overflow_q <= tx_overflow_q | tx_drop;
            io_rx_ready_q <= (rx_count_d != RX_FULL);
            if (!bus.mem_wr) begin
                if (!is_io) begin
                    mem_din_q <= ram[idx];
                end else if (rd_base) begin
                    if (!run_q) begin
                        mem_din_q <= rx_nonempty ? rx_mem[rx_rd_ptr_q] : 8'h00;
                    end
                end else if (rd_stat) begin
                    mem_din_q <= {6'b0, tx_full, rx_nonempty};
                end else begin
                    mem_din_q <= 8'h00;
                end
            end
        end
    end

    assign bus.mem_din  = mem_din_q;
    assign bus.cpu_rdy  = cpu_rdy_q;
    assign io_rx_ready  = io_rx_ready_q;
    assign io_tx_valid  = (tx_count_q != '0);
    assign io_tx_data   = tx_mem[tx_rd_ptr_q];
    assign tx_overflow  = tx_overflow_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: a driver steps one bus cycle at a time and a
// queue-based reference model predicts every response; a monitor compares.
module tb_ram_io_responder;
  localparam logic [31:0] IOB = 32'h30000;

  logic       clk = 1'b0;
  logic       rst;
  logic       io_rx_valid, io_rx_ready, io_tx_valid, io_tx_ready, tx_overflow;
  logic [7:0] io_rx_data, io_tx_data;

  ram_io_responder_if bus();

  ram_io_responder dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .io_rx_valid (io_rx_valid),
    .io_rx_data  (io_rx_data),
    .io_rx_ready (io_rx_ready),
    .io_tx_valid (io_tx_valid),
    .io_tx_data  (io_tx_data),
    .io_tx_ready (io_tx_ready),
    .tx_overflow (tx_overflow)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard queues
  logic [7:0] exp_q[$];      // mem_din after each read/reset edge
  logic [7:0] exp_tx_q[$];   // bytes expected at io_tx_data, in order
  logic [3:0] exp_st_q[$];   // {cpu_rdy, tx_overflow, io_rx_ready, io_tx_valid} after each edge
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] ram_m [int];
  logic [7:0] rx_m[$];
  int         tx_n = 0;
  bit         run_m = 0, ovf_m = 0, rxrdy_m = 0;
  logic [7:0] din_m = 8'h00;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // driver + model: one bus cycle per call
  task automatic step(input bit rst_n, input bit wr, input logic [31:0] a, input logic [7:0] d,
                      input bit rxv, input logic [7:0] rxd, input bit txr);
    bit tx_pop, rx_acc, rdy_pre, io, full_pre, ne_pre;
    @(negedge clk);
    rst = rst_n; bus.mem_wr = wr; bus.mem_a = a; bus.mem_dout = d;
    io_rx_valid = rxv; io_rx_data = rxd; io_tx_ready = txr;
    if (!rst_n) begin
      rx_m.delete(); exp_tx_q.delete();
      tx_n = 0; run_m = 0; ovf_m = 0; rxrdy_m = 0; din_m = 8'h00;
      exp_q.push_back(8'h00);
      exp_st_q.push_back(4'b1000);
    end else begin
      io       = (a >= IOB);
      full_pre = (tx_n == 8);
      ne_pre   = (rx_m.size() > 0);
      rdy_pre  = (tx_n < 7);
      tx_pop   = (tx_n > 0) && txr;
      rx_acc   = rxv && rxrdy_m;
      if (tx_pop) tx_n--;
      if (!wr) begin
        if (!io) din_m = ram_m[int'(a[16:0])];
        else if (a == IOB) begin
          if (!run_m) din_m = ne_pre ? rx_m.pop_front() : 8'h00;
        end
        else if (a == IOB + 4) din_m = {6'b0, full_pre, ne_pre};
        else din_m = 8'h00;
        exp_q.push_back(din_m);
      end else if (!io) begin
        ram_m[int'(a[16:0])] = d;
      end else if (a == IOB) begin
        if (tx_n < 8) begin
          tx_n++;
          exp_tx_q.push_back(d);
        end else begin
          ovf_m = 1;
        end
      end
      if (rx_acc) rx_m.push_back(rxd);
      run_m   = !wr && (a == IOB);
      rxrdy_m = (rx_m.size() < 8);
      exp_st_q.push_back({rdy_pre, ovf_m, rxrdy_m, tx_n > 0});
    end
  endtask

  task automatic rd(input logic [31:0] a, input bit txr);
    step(1, 0, a, 8'h00, 0, 8'h00, txr);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input bit txr);
    step(1, 1, a, d, 0, 8'h00, txr);
  endtask

  // monitor: samples mid-cycle, after the driver has settled inputs
  initial begin
    bit have_prev = 0;
    bit rd_prev = 0;
    logic [3:0] st;
    forever begin
      @(negedge clk);
      #1;
      if (have_prev) begin
        if (exp_st_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL status_queue: empty at %0t", $time);
        end else begin
          st = exp_st_q.pop_front();
          check8("cpu_rdy", {7'b0, bus.cpu_rdy}, {7'b0, st[3]});
          check8("tx_overflow", {7'b0, tx_overflow}, {7'b0, st[2]});
          check8("io_rx_ready", {7'b0, io_rx_ready}, {7'b0, st[1]});
          check8("io_tx_valid", {7'b0, io_tx_valid}, {7'b0, st[0]});
        end
        if (rd_prev) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_din_queue: empty at %0t", $time);
          end else begin
            check8("mem_din", bus.mem_din, exp_q.pop_front());
          end
        end
      end
      if (rst && io_tx_valid && io_tx_ready) begin
        if (exp_tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL io_tx_data: unexpected byte %02h at %0t", io_tx_data, $time);
        end else begin
          check8("io_tx_data", io_tx_data, exp_tx_q.pop_front());
        end
      end
      rd_prev   = !rst || !bus.mem_wr;
      have_prev = 1;
    end
  end

  // stimulus
  initial begin
    logic [31:0] a;
    int sel;
    rst = 1'b0; bus.mem_wr = 1'b0; bus.mem_a = '0; bus.mem_dout = '0;
    io_rx_valid = 1'b0; io_rx_data = '0; io_tx_ready = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // known RAM window for later random reads
    for (int i = 0; i < 64; i++) wr(i, 8'($urandom_range(0, 255)), 0);

    // RAM write then read: data one cycle after the address
    wr(32'h00123, 8'hA5, 0);
    rd(32'h00123, 0);

    // RX run semantics
    step(1, 0, 0, 0, 1, 8'h11, 0);
    step(1, 0, 1, 0, 1, 8'h22, 0);
    rd(IOB, 0);
    rd(IOB, 0);
    rd(32'h00123, 0);
    rd(IOB, 0);
    rd(IOB + 4, 0);

    // fill TX with consumer stalled, then overflow
    for (int i = 0; i < 9; i++) wr(IOB, 8'h40 + 8'(i), 0);
    rd(IOB + 4, 0);

    // full TX: pop and write in the same cycle
    wr(IOB, 8'h99, 1);
    for (int i = 0; i < 9; i++) rd(i, 1);

    // empty RX read while a byte arrives: no bypass
    step(1, 0, IOB, 0, 1, 8'h7E, 0);
    rd(IOB + 4, 0);
    rd(IOB, 0);

    // reset with TX bytes queued; RAM survives
    for (int i = 0; i < 3; i++) wr(IOB, 8'hC0 + 8'(i), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    rd(32'h00123, 0);
    rd(0, 0);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4) a = ($urandom_range(0, 3) == 0 ? 32'h20000 : 32'h0) + 32'($urandom_range(0, 63));
      else if (sel <= 6) a = IOB;
      else if (sel == 7) a = IOB + 4;
      else if (sel == 8) a = IOB + 8;
      else a = 32'hFFFF_FFF0;
      if ($urandom_range(0, 99) == 0) step(0, 0, 0, 0, 0, 0, 0);
      else step(1, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 2) == 0));
    end

    // drain and let the monitor catch up
    for (int i = 0; i < 12; i++) rd(0, 1);
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
